alu_acc_unit: RTL and testbench



---
 rtl/alu_acc_pkg.sv | 22 ++
 rtl/rc_adder_n.sv | 23 ++
 rtl/alu_acc_unit.sv | 160 ++++++++++++++++
 tb/tb_alu_acc_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_acc_pkg.sv
// Shared constants for the accumulator ALU: function codes, FSM state encoding
// and multiply iteration counter width.
package alu_acc_pkg;

    localparam int ALU_W = 4;
    localparam int CNT_W = (ALU_W > 1) ? $clog2(ALU_W) : 1;

    localparam logic [2:0] FN_INC   = 3'b000;
    localparam logic [2:0] FN_ADD   = 3'b001;
    localparam logic [2:0] FN_ADDB  = 3'b010;
    localparam logic [2:0] FN_LOGIC = 3'b011;
    localparam logic [2:0] FN_ROR   = 3'b100;
    localparam logic [2:0] FN_CAT   = 3'b101;
    localparam logic [2:0] FN_MUL   = 3'b110;
    localparam logic [2:0] FN_CLR   = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/rc_adder_n.sv
// Parameterized N-bit ripple-carry adder with carry in and carry out.
module rc_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/alu_acc_unit.sv
// Accumulator-style ALU: operand B is fed back from the low nibble of the result
// register; opcode 110 runs a W-cycle shift-add multiply. Optional sticky carry
// output is enabled with `define ALU_ACC_CARRY_EN.
module alu_acc_unit
    import alu_acc_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [2:0]     func,
    output logic [2*W-1:0] result,
    output logic           out_valid,
    output logic           busy
`ifdef ALU_ACC_CARRY_EN
    ,
    output logic           carry
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       mcand;
    logic [W-1:0]       mplier;
    logic [2*W-1:0]     acc;

    logic [W-1:0]       opb;
    logic               accept;
    logic               mul_last;

    logic               add_inc;
    logic [W-1:0]       add_b;
    logic [W-1:0]       add_sum;
    logic               add_cout;

    logic [2*W-1:0]     partial;
    logic [2*W-1:0]     acc_sum;
    logic               mac_cout_unused;

    logic [2*W-1:0]     op_res;

    assign opb      = result[W-1:0];
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_MUL);
    assign accept   = in_valid && in_ready;
    assign mul_last = (cnt == CNT_W'(W - 1));

    // Increment shares the W-bit adder by forcing B to zero and carry-in to one.
    assign add_inc = (func == FN_INC);
    assign add_b   = add_inc ? '0 : opb;

    rc_adder_n #(.N(W)) u_add (
        .a    (a),
        .b    (add_b),
        .cin  (add_inc),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The product of two W-bit values always fits in 2W bits, so the
    // accumulator carry-out is never meaningful.
    assign partial = mplier[cnt] ? ({{W{1'b0}}, mcand} << cnt) : '0;

    rc_adder_n #(.N(2*W)) u_mac (
        .a    (acc),
        .b    (partial),
        .cin  (1'b0),
        .sum  (acc_sum),
        .cout (mac_cout_unused)
    );

    always_comb begin
        op_res = '0;
        case (func)
            FN_INC,
            FN_ADD:   op_res = {{(W-1){1'b0}}, add_cout, add_sum};
            FN_ADDB:  op_res = {{W{1'b0}}, a} + {{W{1'b0}}, opb};
            FN_LOGIC: op_res = {a | opb, a ^ opb};
            FN_ROR:   op_res = {{(2*W-1){1'b0}}, |{a, opb}};
            FN_CAT:   op_res = {a, opb};
            default:  op_res = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && (func == FN_MUL)) state_nxt = ST_MUL;
            ST_MUL:  if (mul_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (func == FN_MUL) begin
                            mcand  <= a;
                            mplier <= opb;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            result    <= op_res;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc <= acc_sum;
                    if (mul_last) begin
                        result    <= acc_sum;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ACC_CARRY_EN
    // Sticky overflow of the add-type ops; only a clear op or reset drops it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            carry <= 1'b0;
        end else if (accept) begin
            if (func == FN_CLR) begin
                carry <= 1'b0;
            end else if (((func == FN_INC) || (func == FN_ADD) || (func == FN_ADDB)) && op_res[W]) begin
                carry <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_acc_unit.sv
// Directed self-checking bench for alu_acc_unit with hand-computed expectations;
// covers the sticky carry output when ALU_ACC_CARRY_EN is defined.
module tb_alu_acc_unit;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [2:0] func;
    logic [7:0] result;
    logic       out_valid;
    logic       busy;
`ifdef ALU_ACC_CARRY_EN
    logic       carry;
`endif

    int total = 0;
    int bad   = 0;

    alu_acc_unit #(.W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .func      (func),
        .result    (result),
        .out_valid (out_valid),
        .busy      (busy)
`ifdef ALU_ACC_CARRY_EN
        ,
        .carry     (carry)
`endif
    );

    initial begin
        clock = 1'b0;
        #5;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic iv, input logic [3:0] av, input logic [2:0] fv);
        in_valid = iv;
        a        = av;
        func     = fv;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCarry(input string tag, input logic expected);
`ifdef ALU_ACC_CARRY_EN
        checkOutput(tag, {7'b0, carry}, {7'b0, expected});
`else
        if (expected === 1'bx) $display("[TB] %s", tag);
`endif
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 4'h0, 3'b000);
        #2;
        checkOutput("rst_result", result, 8'h00);
        checkOutput("rst_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("rst_in_ready", {7'b0, in_ready}, 8'h01);
        checkOutput("rst_busy", {7'b0, busy}, 8'h00);
        checkCarry("rst_carry", 1'b0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("post_rst_out_valid", {7'b0, out_valid}, 8'h00);

        // Add from zero, then back-to-back add using fed-back B
        applyStimulus(1'b1, 4'h5, 3'b001);
        tick();
        checkOutput("add5_result", result, 8'h05);
        checkOutput("add5_out_valid", {7'b0, out_valid}, 8'h01);
        applyStimulus(1'b1, 4'h3, 3'b001);
        tick();
        checkOutput("add3_result", result, 8'h08);
        checkOutput("add3_out_valid", {7'b0, out_valid}, 8'h01);
        applyStimulus(1'b0, 4'h0, 3'b000);
        tick();
        checkOutput("idle_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("idle_result", result, 8'h08);

        // Clear, increment with carry out, sticky carry until clear
        applyStimulus(1'b1, 4'h0, 3'b111);
        tick();
        checkOutput("clr_result", result, 8'h00);
        applyStimulus(1'b1, 4'hF, 3'b000);
        tick();
        checkOutput("incF_result", result, 8'h10);
        checkCarry("incF_carry", 1'b1);
        applyStimulus(1'b1, 4'h0, 3'b100);
        tick();
        checkOutput("or_zero_result", result, 8'h00);
        checkCarry("carry_sticky", 1'b1);
        applyStimulus(1'b1, 4'h0, 3'b111);
        tick();
        checkCarry("carry_cleared", 1'b0);

        // Logic, concat, reduction OR, wide add
        applyStimulus(1'b1, 4'h5, 3'b001);
        tick();
        checkOutput("load5_result", result, 8'h05);
        checkCarry("add_no_carry", 1'b0);
        applyStimulus(1'b1, 4'hA, 3'b011);
        tick();
        checkOutput("logic_result", result, 8'hFF);
        applyStimulus(1'b1, 4'h3, 3'b101);
        tick();
        checkOutput("cat_result", result, 8'h3F);
        applyStimulus(1'b1, 4'h0, 3'b100);
        tick();
        checkOutput("or_result", result, 8'h01);
        applyStimulus(1'b1, 4'hF, 3'b010);
        tick();
        checkOutput("addb_result", result, 8'h10);
        checkCarry("addb_carry", 1'b1);
        applyStimulus(1'b1, 4'h0, 3'b111);
        tick();
        checkOutput("clr2_result", result, 8'h00);

        // Multiply 9 * 7 with a request held during MUL
        applyStimulus(1'b1, 4'h7, 3'b001);
        tick();
        checkOutput("load7_result", result, 8'h07);
        applyStimulus(1'b0, 4'h0, 3'b000);
        tick();
        applyStimulus(1'b1, 4'h9, 3'b110);
        tick();
        checkOutput("mul_accept_ready", {7'b0, in_ready}, 8'h00);
        checkOutput("mul_accept_busy", {7'b0, busy}, 8'h01);
        checkOutput("mul_accept_out_valid", {7'b0, out_valid}, 8'h00);
        applyStimulus(1'b1, 4'h1, 3'b001);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput($sformatf("mul_cyc%0d_busy", i), {7'b0, busy}, 8'h01);
            checkOutput($sformatf("mul_cyc%0d_ready", i), {7'b0, in_ready}, 8'h00);
            checkOutput($sformatf("mul_cyc%0d_result", i), result, 8'h07);
            checkOutput($sformatf("mul_cyc%0d_out_valid", i), {7'b0, out_valid}, 8'h00);
        end
        tick();
        checkOutput("mul_done_result", result, 8'h3F);
        checkOutput("mul_done_out_valid", {7'b0, out_valid}, 8'h01);
        checkOutput("mul_done_ready", {7'b0, in_ready}, 8'h01);
        checkOutput("mul_done_busy", {7'b0, busy}, 8'h00);
        applyStimulus(1'b0, 4'h0, 3'b000);
        tick();
        checkOutput("mul_after_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("mul_after_result", result, 8'h3F);

        // Reset in the middle of a multiply
        applyStimulus(1'b1, 4'h9, 3'b110);
        tick();
        applyStimulus(1'b0, 4'h0, 3'b000);
        tick();
        tick();
        checkOutput("mid_mul_busy", {7'b0, busy}, 8'h01);
        reset = 1'b1;
        #1;
        checkOutput("abort_result", result, 8'h00);
        checkOutput("abort_ready", {7'b0, in_ready}, 8'h01);
        checkOutput("abort_busy", {7'b0, busy}, 8'h00);
        checkOutput("abort_out_valid", {7'b0, out_valid}, 8'h00);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("abort_after%0d_out_valid", i), {7'b0, out_valid}, 8'h00);
            checkOutput($sformatf("abort_after%0d_result", i), result, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
